lopd_norm_pipe: RTL and testbench

Pipelined, parametrised successor to the combinational leading-one position detector used in mantissa normalisation. It accepts a SIZE_DATA-bit operand with a tag over a valid/ready handshake. A per-transaction mode bit selects leading-one (MSB-first) or trailing-one (LSB-first) search. Two register stages later it returns the position, a zero flag and the operand normalised by that position. It sits between the FP add/sub datapath and the rounding stage and carries the address tag through unchanged.

---
 rtl/lopd_norm_pipe.sv | 161 ++++++++++++++++
 tb/tb_lopd_norm_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lopd_norm_pipe.sv
// Two-stage leading/trailing-one position detector with normaliser.
// Stage 1 captures the operand, its tag, the search mode and the detected
// position/zero flag; stage 2 captures the shifted operand and drives every
// output. A valid/ready handshake on each side lets the pipeline stall
// without losing, duplicating or reordering transactions.
module lopd_norm_pipe #(
  parameter int SIZE_DATA = 24,
  parameter int SIZE_LOPD = 5,
  parameter int SIZE_ADDR = 24,
  parameter int SIZE_CNT  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_mode,
  input  logic [SIZE_ADDR-1:0] i_addr,
  input  logic [SIZE_DATA-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_ADDR-1:0] o_addr,
  output logic [SIZE_LOPD-1:0] o_one_position,
  output logic                 o_zero_flag,
  output logic [SIZE_DATA-1:0] o_norm_data,
  output logic [SIZE_CNT-1:0]  o_zero_cnt
);

  // Stage 1 state
  logic                 s1_valid_q, s1_valid_d;
  logic [SIZE_DATA-1:0] s1_data_q,  s1_data_d;
  logic [SIZE_ADDR-1:0] s1_addr_q,  s1_addr_d;
  logic                 s1_mode_q,  s1_mode_d;
  logic [SIZE_LOPD-1:0] s1_pos_q,   s1_pos_d;
  logic                 s1_zero_q,  s1_zero_d;

  // Stage 2 state (drives the outputs)
  logic                 s2_valid_q, s2_valid_d;
  logic [SIZE_ADDR-1:0] s2_addr_q,  s2_addr_d;
  logic [SIZE_LOPD-1:0] s2_pos_q,   s2_pos_d;
  logic                 s2_zero_q,  s2_zero_d;
  logic [SIZE_DATA-1:0] s2_norm_q,  s2_norm_d;
  logic [SIZE_CNT-1:0]  zero_cnt_q, zero_cnt_d;

  // Handshake / datapath helpers
  logic                 out_xfer, in_xfer, s2_load, s1_advance;
  logic [SIZE_LOPD-1:0] det_pos;
  logic                 det_zero;
  logic [SIZE_LOPD-1:0] left_shamt;
  logic [SIZE_DATA-1:0] shifted;

  // Handshake: S2 frees up when its result leaves; S1 frees up when it moves to S2
  always_comb begin
    out_xfer   = s2_valid_q & i_ready;
    s2_load    = ~s2_valid_q | out_xfer;
    s1_advance = s1_valid_q & s2_load;
    o_ready    = ~s1_valid_q | s1_advance;
    in_xfer    = i_valid & o_ready;
  end

  // Position search on the incoming operand; later matches overwrite earlier ones
  always_comb begin
    det_pos  = '0;
    det_zero = (i_data == '0);
    if (!i_mode) begin
      for (int i = 0; i < SIZE_DATA; i++) begin
        if (i_data[i]) det_pos = SIZE_LOPD'(i);
      end
    end else begin
      for (int i = SIZE_DATA - 1; i >= 0; i--) begin
        if (i_data[i]) det_pos = SIZE_LOPD'(i);
      end
    end
  end

  // Normalising shift on the stage-1 operand; a zero operand shifts to zero
  always_comb begin
    left_shamt = SIZE_LOPD'(SIZE_DATA - 1) - s1_pos_q;
    if (s1_mode_q) shifted = s1_data_q >> s1_pos_q;
    else           shifted = s1_data_q << left_shamt;
  end

  // Next-state for both stages and the saturating zero counter
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_addr_d  = s1_addr_q;
    s1_mode_d  = s1_mode_q;
    s1_pos_d   = s1_pos_q;
    s1_zero_d  = s1_zero_q;
    s2_valid_d = s2_valid_q;
    s2_addr_d  = s2_addr_q;
    s2_pos_d   = s2_pos_q;
    s2_zero_d  = s2_zero_q;
    s2_norm_d  = s2_norm_q;
    zero_cnt_d = zero_cnt_q;

    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_data_d  = i_data;
      s1_addr_d  = i_addr;
      s1_mode_d  = i_mode;
      s1_pos_d   = det_pos;
      s1_zero_d  = det_zero;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_addr_d = s1_addr_q;
        s2_pos_d  = s1_pos_q;
        s2_zero_d = s1_zero_q;
        s2_norm_d = shifted;
      end
    end

    if (out_xfer && s2_zero_q && (zero_cnt_q != {SIZE_CNT{1'b1}})) begin
      zero_cnt_d = zero_cnt_q + 1'b1;
    end
  end

  // Pipeline registers with synchronous clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_addr_q  <= '0;
      s1_mode_q  <= 1'b0;
      s1_pos_q   <= '0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_pos_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_norm_q  <= '0;
      zero_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_addr_q  <= s1_addr_d;
      s1_mode_q  <= s1_mode_d;
      s1_pos_q   <= s1_pos_d;
      s1_zero_q  <= s1_zero_d;
      s2_valid_q <= s2_valid_d;
      s2_addr_q  <= s2_addr_d;
      s2_pos_q   <= s2_pos_d;
      s2_zero_q  <= s2_zero_d;
      s2_norm_q  <= s2_norm_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

  assign o_valid        = s2_valid_q;
  assign o_addr         = s2_addr_q;
  assign o_one_position = s2_pos_q;
  assign o_zero_flag    = s2_zero_q;
  assign o_norm_data    = s2_norm_q;
  assign o_zero_cnt     = zero_cnt_q;

endmodule

// File: tb/tb_lopd_norm_pipe.sv
// Bench for lopd_norm_pipe: directed vector table, hand sequences for
// latency/backpressure/reset, and a random stream, all checked through an
// in-order scoreboard. The counter is built 2 bits wide so saturation shows.
module tb_lopd_norm_pipe;
  localparam int SD = 24;
  localparam int SL = 5;
  localparam int SA = 24;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic          i_mode = 1'b0;
  logic [SA-1:0] i_addr = '0;
  logic [SD-1:0] i_data = '0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [SA-1:0] o_addr;
  logic [SL-1:0] o_one_position;
  logic          o_zero_flag;
  logic [SD-1:0] o_norm_data;
  logic [SC-1:0] o_zero_cnt;

  always #5 clk = ~clk;

  lopd_norm_pipe #(.SIZE_DATA(SD), .SIZE_LOPD(SL), .SIZE_ADDR(SA), .SIZE_CNT(SC)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mode(i_mode), .i_addr(i_addr), .i_data(i_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_addr(o_addr), .o_one_position(o_one_position),
    .o_zero_flag(o_zero_flag), .o_norm_data(o_norm_data), .o_zero_cnt(o_zero_cnt)
  );

  typedef struct {
    logic          mode;
    logic [SD-1:0] data;
    logic [SL-1:0] pos;
    logic          zero;
    logic [SD-1:0] norm;
  } vec_t;

  typedef struct {
    logic [SA-1:0] addr;
    logic [SL-1:0] pos;
    logic          zero;
    logic [SD-1:0] norm;
  } exp_t;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  logic [SC-1:0] exp_cnt = '0;
  logic [SA-1:0] tag = '0;
  bit            rnd_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Reference model written from the behavioural definition
  function automatic exp_t ref_model(input logic mode, input logic [SD-1:0] d, input logic [SA-1:0] a);
    exp_t e;
    e.addr = a;
    e.pos  = '0;
    e.zero = (d == '0);
    if (!mode) begin
      for (int i = SD - 1; i >= 0; i--) if (d[i]) begin e.pos = SL'(i); break; end
    end else begin
      for (int i = 0; i < SD; i++) if (d[i]) begin e.pos = SL'(i); break; end
    end
    if (e.zero) e.norm = '0;
    else if (!mode) e.norm = d << (SD - 1 - int'(e.pos));
    else e.norm = d >> e.pos;
    return e;
  endfunction

  // Drive one operand, push its expectation at the accepting edge
  task automatic send(input logic mode, input logic [SD-1:0] d, input exp_t e);
    int waited;
    waited = 0;
    i_valid = 1'b1;
    i_mode  = mode;
    i_data  = d;
    i_addr  = e.addr;
    forever begin
      @(negedge clk);
      if (o_ready) begin
        sb_q.push_back(e);
        break;
      end
      waited++;
      if (waited > 300) begin
        chk("send_timeout", 32'(waited), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    exp_t e;
    tag = tag + 1'b1;
    e.addr = tag; e.pos = v.pos; e.zero = v.zero; e.norm = v.norm;
    send(v.mode, v.data, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin @(posedge clk); n++; end
    if (sb_q.size() != 0) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Output monitor: stall stability, in-order scoreboard and counter model
  logic          stalled = 1'b0;
  logic [SA-1:0] h_addr;
  logic [SL-1:0] h_pos;
  logic          h_zero;
  logic [SD-1:0] h_norm;
  always @(negedge clk) begin
    if (i_rst) begin
      sb_q.delete();
      exp_cnt = '0;
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_addr", 32'(o_addr), 32'(h_addr));
        chk("hold_norm", 32'(o_norm_data), 32'(h_norm));
        chk("hold_pos", 32'(o_one_position), 32'(h_pos));
        chk("hold_zero", 32'(o_zero_flag), 32'(h_zero));
      end
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out_addr", 32'(o_addr), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("out_addr", 32'(o_addr), 32'(e.addr));
          chk("out_pos", 32'(o_one_position), 32'(e.pos));
          chk("out_zero", 32'(o_zero_flag), 32'(e.zero));
          chk("out_norm", 32'(o_norm_data), 32'(e.norm));
          chk("out_zero_cnt", 32'(o_zero_cnt), 32'(exp_cnt));
          if (e.zero && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
          $display("xfer addr=%06h pos=%0d zero=%0d norm=%06h cnt=%0d",
                   o_addr, o_one_position, o_zero_flag, o_norm_data, o_zero_cnt);
        end
      end
      stalled = o_valid && !i_ready;
      h_addr = o_addr; h_pos = o_one_position; h_zero = o_zero_flag; h_norm = o_norm_data;
    end
  end

  vec_t vecs[$];

  initial begin
    vec_t v;
    exp_t e;
    logic [SD-1:0] d;
    logic          m;

    // Directed table: single-one sweep, mixed bits, zero operands
    for (int k = 0; k < SD; k++) begin
      v.mode = 1'b0; v.data = SD'(1) << k; v.pos = SL'(k); v.zero = 1'b0; v.norm = 24'h800000;
      vecs.push_back(v);
    end
    vecs.push_back('{1'b0, 24'h00F0A3, 5'd15, 1'b0, 24'hF0A300});
    vecs.push_back('{1'b1, 24'h00F0A3, 5'd0,  1'b0, 24'h00F0A3});
    vecs.push_back('{1'b1, 24'h0A0000, 5'd17, 1'b0, 24'h000005});
    vecs.push_back('{1'b1, 24'h800000, 5'd23, 1'b0, 24'h000001});
    vecs.push_back('{1'b0, 24'h000000, 5'd0,  1'b1, 24'h000000});
    vecs.push_back('{1'b1, 24'h000000, 5'd0,  1'b1, 24'h000000});
    vecs.push_back('{1'b0, 24'h000000, 5'd0,  1'b1, 24'h000000});
    vecs.push_back('{1'b1, 24'h000000, 5'd0,  1'b1, 24'h000000});
    vecs.push_back('{1'b0, 24'h000000, 5'd0,  1'b1, 24'h000000});

    // Reset state
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_addr", 32'(o_addr), 32'd0);
    chk("rst_pos", 32'(o_one_position), 32'd0);
    chk("rst_zero", 32'(o_zero_flag), 32'd0);
    chk("rst_norm", 32'(o_norm_data), 32'd0);
    chk("rst_cnt", 32'(o_zero_cnt), 32'd0);
    @(posedge clk); #1;

    // Table applied back to back
    for (int i = 0; i < vecs.size(); i++) send_vec(vecs[i]);
    drain();
    chk("zero_cnt_saturated", 32'(o_zero_cnt), 32'd3);

    // Latency: result appears exactly two edges after acceptance
    send_vec('{1'b0, 24'h000300, 5'd9, 1'b0, 24'hC00000});
    @(negedge clk);
    chk("latency_1cyc_valid", 32'(o_valid), 32'd0);
    @(negedge clk);
    chk("latency_2cyc_valid", 32'(o_valid), 32'd1);
    drain();

    // Backpressure: six operands, downstream blocked, release later
    i_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          tag = tag + 1'b1;
          d = SD'(3) << (k * 3);
          send(1'b0, d, ref_model(1'b0, d, tag));
        end
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_ready_low", 32'(o_ready), 32'd0);
        chk("bp_queue_two", 32'(sb_q.size()), 32'd2);
        repeat (4) @(posedge clk);
        #1 i_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages full: nothing from before may surface
    i_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tag = tag + 1'b1;
      send(1'b1, 24'h000010, ref_model(1'b1, 24'h000010, tag));
    end
    @(negedge clk);
    chk("full_ready_low", 32'(o_ready), 32'd0);
    @(posedge clk); #1 i_rst = 1'b1;
    @(posedge clk); #1 i_rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_cnt", 32'(o_zero_cnt), 32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    #1 i_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("post_rst_idle", 32'(o_valid), 32'd0);
    @(posedge clk); #1;

    // Random stream with random gaps and random downstream stalls
    rnd_on = 1'b1;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          d = SD'(1) << $urandom_range(0, SD - 1);
          if ($urandom_range(0, 1) == 1) d = d | SD'($urandom);
          if ($urandom_range(0, 24) == 0) d = '0;
          m = 1'($urandom_range(0, 1));
          tag = SA'($urandom);
          send(m, d, ref_model(m, d, tag));
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    i_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
